// File: rtl/mdr_pkg.sv
// Shared MDR datapath definitions: operand/product widths, multiplier FSM states.
package mdr_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned PW         = 2 * DW;
  localparam int unsigned MULT_CNT_W = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mdr_multiplier_if.sv
// Start/Ready handshake and operand/product bus of the MDR multiplier.
interface mdr_multiplier_if;

  logic                     start;
  logic [mdr_pkg::DW-1:0]   Multiplicand;
  logic [mdr_pkg::DW-1:0]   Multiplier;
  logic                     Ready;
  logic                     Busy;
  logic [mdr_pkg::PW-1:0]   Product;

  modport master (
    output start, Multiplicand, Multiplier,
    input  Ready, Busy, Product
  );

  modport slave (
    input  start, Multiplicand, Multiplier,
    output Ready, Busy, Product
  );

endinterface

// File: rtl/mdr_mult_counter.sv
// Iteration counter for the multiplier; term_o flags the last iteration (DW-1).
module mdr_mult_counter
  import mdr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enb_i,
  input  logic sync_rst_i,
  output logic term_o
);

  logic [MULT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  term_q, term_d;

  // Next count and registered terminal flag
  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    if (sync_rst_i) begin
      cnt_d  = '0;
      term_d = 1'b0;
    end else if (enb_i) begin
      cnt_d  = cnt_q + MULT_CNT_W'(1);
      term_d = (cnt_d == MULT_CNT_W'(DW - 1));
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/mdr_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Optional two's-complement operands when MDR_MULT_SIGNED_EN is defined.
module mdr_multiplier
  import mdr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mdr_multiplier_if.slave bus
);

  mult_state_t   state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] product_q, product_d;
  logic          ready_q, ready_d, busy_q, busy_d;
  logic          cnt_enb, cnt_clr, cnt_term;
  logic [DW-1:0] mag_a, mag_b;
  logic [PW-1:0] result;
`ifdef MDR_MULT_SIGNED_EN
  logic          sign_q, sign_d;

  // Magnitudes of the captured operands and sign-corrected result
  always_comb begin
    mag_a  = a_q[DW-1] ? DW'(~a_q + DW'(1)) : a_q;
    mag_b  = b_q[DW-1] ? DW'(~b_q + DW'(1)) : b_q;
    result = sign_q ? PW'(~acc_q + PW'(1)) : acc_q;
  end
`else
  // Unsigned operands pass straight through
  always_comb begin
    mag_a  = a_q;
    mag_b  = b_q;
    result = acc_q;
  end
`endif

  mdr_mult_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .enb_i      (cnt_enb),
    .sync_rst_i (cnt_clr),
    .term_o     (cnt_term)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_enb   = 1'b0;
    cnt_clr   = 1'b0;
`ifdef MDR_MULT_SIGNED_EN
    sign_d    = sign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.Multiplicand;
          b_d     = bus.Multiplier;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d    = '0;
        mcand_d  = PW'(mag_a);
        mplier_d = mag_b;
        cnt_clr  = 1'b1;
`ifdef MDR_MULT_SIGNED_EN
        sign_d   = a_q[DW-1] ^ b_q[DW-1];
`endif
        state_d  = CALC;
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_enb  = 1'b1;
        if (cnt_term) state_d = DONE;
      end
      DONE: begin
        product_d = result;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_q == DONE);
    busy_d  = (state_d == LOAD) || (state_d == CALC);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MDR_MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef MDR_MULT_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign bus.Ready   = ready_q;
  assign bus.Busy    = busy_q;
  assign bus.Product = product_q;

endmodule

// File: doc/mdr_multiplier.md
Name: mdr_multiplier

Overview:
- Sequential shift-and-add multiplier, the inverse-operation companion of the repeated-subtraction divider in the MDR datapath.
- Accepts two DW-bit operands on a start pulse and iterates one multiplier bit per clock.
- Presents a 2*DW-bit product with a one-cycle Ready pulse.
- Sits beside the divider under the same MDR top level and shares its start/Ready handshake semantics.

Parameters:
- DW, 16 (from mdr_pkg): operand width.
- PW, 2*DW (derived in mdr_pkg): product width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- Multiplicand  input  DW  operand A; captured on the start edge.
- Multiplier  input  DW  operand B; captured on the start edge.
- Ready  output  1  one-cycle pulse: Product valid and new.
- Busy  output  1  high in LOAD and CALC.
- Product  output  PW  result register; holds until the next operation completes.

Behaviour:
- Reset (async, rst=1): state=IDLE, Ready=0, Busy=0, Product=0, all internal registers 0. Applies at any time, including mid-operation; the operation in flight is discarded and no Ready is produced.
- State machine: IDLE -> LOAD -> CALC -> DONE -> IDLE.
- IDLE: if start=1 at the edge, capture both operands, go to LOAD. Otherwise stay.
- LOAD (1 cycle):
  - acc = 0 (PW bits); mcand = zero-extended Multiplicand (PW bits); mplier = Multiplier (DW bits); bit counter = 0.
  - Go to CALC.
- CALC (exactly DW cycles, fixed latency, no early exit on zero operands). Each cycle:
  - if mplier[0]: acc = acc + mcand (modulo 2^PW; cannot overflow for unsigned operands).
  - mcand <<= 1; mplier >>= 1; counter += 1.
  - When counter reaches DW-1 on this cycle's edge, go to DONE.
- DONE (1 cycle): Product <= acc, registered on entry. Ready=1 for this cycle only. Go to IDLE.
- Latency: start sampled at edge 0; Ready high in the cycle after edge DW+2; Product valid from that same edge.
- Busy=1 in LOAD and CALC, 0 in IDLE and DONE.
- start while in LOAD, CALC or DONE is ignored, with no queuing. A start held high through DONE launches a new operation on the first IDLE edge.
- Operand inputs may change freely after the start edge.
- Counter width is $clog2(DW). It must not wrap before DONE is reached.

Optional Feature:
- Macro MDR_MULT_SIGNED_EN.
- Defined: operands are two's complement.
  - LOAD loads magnitudes |A| and |B| as unsigned DW bits; -2^(DW-1) gives magnitude 2^(DW-1).
  - A sign flag is set to A[DW-1] ^ B[DW-1].
  - On DONE entry, Product <= sign ? (~acc + 1) : acc.
  - Latency unchanged.
- Undefined: operands are unsigned, with no sign logic.

Decomposition:
- mdr_pkg gains:
  - PW = 2*DW.
  - mult_state_t enum {IDLE, LOAD, CALC, DONE}.
  - MULT_CNT_W = $clog2(DW).
- One sub-module, mdr_mult_counter: bit counter with enb, sync_rst, and a terminal flag at DW-1. Mirrors the divider's counter and is instantiated once.

Test Plan:
- Multiplicand=3, Multiplier=5, start for 1 cycle -> Ready pulses exactly 18 cycles after the start edge (DW=16); Product=32'h0000000F; Busy high 17 cycles.
- 16'hFFFF x 16'hFFFF (macro off) -> Product=32'hFFFE0001. Then 0 x 16'h1234 -> Product=0 with the same fixed latency.
- start re-pulsed during CALC with different operands -> ignored; first result delivered unchanged; a single Ready pulse.
- rst asserted at CALC cycle 7 -> immediately Ready=0, Busy=0, Product=0. Next start 6 x 7 -> Product=42 after normal latency.
- Macro on:
  - -3 x 5 -> 32'hFFFFFFF1.
  - -32768 x -32768 -> 32'h40000000.
  - 7 x -1 -> 32'hFFFFFFF9.
- start held high continuously -> back-to-back operations, one Ready per 19 cycles; Product stable between Ready pulses.
